mdu: RTL and testbench
======================

MDU -- requirements
Module: mdu

Interface
REQ-001 SHALL have port clk, input, 1 bit: clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous, active-low.
REQ-003 SHALL have port start, input, 1 bit: launch a multiply or divide.
REQ-004 SHALL have port ALU2Op, input, 2 bits: operation, 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-005 SHALL have ports A and B, input, 32 bits each: rs operand (multiplicand/dividend) and rt operand (multiplier/divisor).
REQ-006 SHALL have port RHLWr, input, 1 bit: HI/LO write request.
REQ-007 SHALL have port RHLSel_Wr, input, 2 bits: write source, 00 A->LO (MTLO), 01 A->HI (MTHI), 10 operation result.
REQ-008 SHALL have port RHLSel_Rd, input, 1 bit: read select, 1 HI, 0 LO.
REQ-009 SHALL have port flush, input, 1 bit: exception/eret flush; abort the current operation.
REQ-010 SHALL have port busy, output, 1 bit: operation in progress; registered.
REQ-011 SHALL have port rdata, output, 32 bits: RHLSel_Rd ? HI : LO, combinational from registered HI/LO, with no forwarding.

Function
REQ-012 SHALL implement states IDLE, MUL, DIV, FIX; busy = (state != IDLE).
REQ-013 SHALL accept start only in IDLE with flush=0, and SHALL latch A, B and ALU2Op on the accept edge.
REQ-014 SHALL, on an accepted MULT or MULTU, go IDLE->MUL for exactly 1 cycle, write {HI,LO} = 64-bit product (signed for MULT) at the end of the MUL cycle, then return to IDLE.
REQ-015 SHALL make multiply results visible on rdata 2 cycles after the accept edge, with busy high for 1 cycle.
REQ-016 SHALL, on an accepted DIV or DIVU, run 32 cycles in DIV (radix-2 restoring, one quotient bit per cycle, 5-bit counter 0..31), then 1 cycle in FIX, then return to IDLE; busy SHALL be high for 33 cycles.
REQ-017 SHALL, for DIV, divide operand magnitudes; quotient negated when sign(A)^sign(B); remainder carries sign(A).
REQ-018 SHALL write LO=quotient and HI=remainder at the end of FIX.
REQ-019 SHALL, for 0x80000000 / 0xFFFFFFFF (DIV), produce LO=0x80000000 and HI=0 without a trap.
REQ-020 SHALL, for divisor 0 (DIV or DIVU), run the full 33 busy cycles and leave HI/LO unwritten.
REQ-021 SHALL, when RHLWr=1, RHLSel_Wr!=10, state IDLE and flush=0, write A to HI or LO on that edge; busy stays low.
REQ-022 SHALL ignore RHLWr and start while busy=1; upstream stalls the instruction.
REQ-023 SHALL, on flush=1 in any state, go to IDLE on the next edge, clear the counter, leave HI/LO unwritten, and suppress any start or MT presented in the same cycle.
REQ-024 SHALL ignore RHLWr with RHLSel_Wr=10 and start=0.
REQ-025 SHALL keep RHLSel_Wr=11 reserved, with no write.

Reset
REQ-026 SHALL, on rst=0 at a clock edge: state=IDLE, busy=0, HI=0, LO=0, counter=0, operand/remainder/quotient registers=0; reset overrides flush and start.
REQ-027 SHALL, on reset asserted mid-operation, abandon the operation and leave HI=LO=0.

Structure
REQ-028 SHALL define the ALU2Op encodings, RHLSel_Wr encodings and state encodings in the shared macro definitions file (MacroDef.v), used by both ctrl and mdu.
REQ-029 SHALL place the iterative restoring divide datapath (partial remainder, quotient shift register, counter) in one sub-module, mdu_div; the multiplier stays inline.

Verification
REQ-030 SHALL check MULT A=0xFFFFFFFE, B=3 -> HI=0xFFFFFFFF, LO=0xFFFFFFFA; busy high exactly 1 cycle.
REQ-031 SHALL check MULTU A=B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
REQ-032 SHALL check DIV A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; busy high 33 cycles, result on rdata at cycle 34.
REQ-033 SHALL check DIV A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0; then DIVU A=100, B=0 -> HI/LO unchanged after 33 busy cycles.
REQ-034 SHALL check DIVU 100/7 with flush on busy cycle 10 -> busy=0 next cycle, HI/LO unchanged; a subsequent DIVU 100/7 gives LO=14, HI=2.
REQ-035 SHALL check MTHI A=0x12345678 while busy -> ignored; MTHI when idle -> rdata=0x12345678 with RHLSel_Rd=1 on the next cycle.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: operation codes, HI/LO
// write-source selects and the controller state encoding.
package mdu_pkg;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } alu2op_e;

  typedef enum logic [1:0] {
    WR_LO  = 2'b00,  // MTLO: A -> LO
    WR_HI  = 2'b01,  // MTHI: A -> HI
    WR_RES = 2'b10,  // operation result (written by the FSM, not by RHLWr)
    WR_RSV = 2'b11   // reserved, never writes
  } hlwsel_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MUL  = 2'b01,
    S_DIV  = 2'b10,
    S_FIX  = 2'b11
  } state_e;

  localparam int DIV_CNT_W = 5;  // 32 quotient bits, one per cycle

  // Magnitude of a 32-bit operand; only negated when treated as signed.
  function automatic logic [31:0] mag32(input logic [31:0] x, input logic sgn);
    return (sgn && x[31]) ? (~x + 32'd1) : x;
  endfunction

endpackage

// File: rtl/mdu_if.sv
// Pipeline <-> MDU bus: launch/operands, HI/LO move requests, flush,
// and the busy/read-data responses.
interface mdu_if;
  logic        start;
  logic [1:0]  ALU2Op;
  logic [31:0] A;
  logic [31:0] B;
  logic        RHLWr;
  logic [1:0]  RHLSel_Wr;
  logic        RHLSel_Rd;
  logic        flush;
  logic        busy;
  logic [31:0] rdata;

  modport master (
    output start, ALU2Op, A, B, RHLWr, RHLSel_Wr, RHLSel_Rd, flush,
    input  busy, rdata
  );

  modport slave (
    input  start, ALU2Op, A, B, RHLWr, RHLSel_Wr, RHLSel_Rd, flush,
    output busy, rdata
  );
endinterface

// File: rtl/mdu_div.sv
// Iterative radix-2 restoring divider on unsigned magnitudes.
// One quotient bit per step; counter runs 0..31 and flags the last step.
module mdu_div
  import mdu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_i,   // capture operands, restart
  input  logic                 step_i,   // perform one restoring step
  input  logic                 clear_i,  // abort: counter back to 0
  input  logic [31:0]          dvd_i,
  input  logic [31:0]          dvs_i,
  output logic [31:0]          quo_o,
  output logic [31:0]          rem_o,
  output logic                 last_o
);

  logic [31:0]          rem_q, rem_d;
  logic [31:0]          quo_q, quo_d;   // dividend bits shift out, quotient bits shift in
  logic [31:0]          dvs_q, dvs_d;
  logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
  logic [32:0]          shifted;
  logic                 ge;

  // Next-state for the partial remainder, quotient shifter and counter.
  always_comb begin
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    shifted = {rem_q, quo_q[31]};
    ge      = (shifted >= {1'b0, dvs_q});
    if (clear_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      rem_d = '0;
      quo_d = dvd_i;
      dvs_d = dvs_i;
      cnt_d = '0;
    end else if (step_i) begin
      // When ge, shifted < 2*divisor so the difference fits in 32 bits.
      rem_d = ge ? (shifted[31:0] - dvs_q) : shifted[31:0];
      quo_d = {quo_q[30:0], ge};
      cnt_d = cnt_q + 5'd1;
    end
  end

  // Divider state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
    end
  end

  assign quo_o  = quo_q;
  assign rem_o  = rem_q;
  assign last_o = (cnt_q == 5'd31);

endmodule

// File: rtl/mdu.sv
// Multiply/divide unit with HI/LO registers. Multiply completes in one
// MUL cycle; divide runs 32 DIV steps plus one FIX cycle for sign repair.
module mdu
  import mdu_pkg::*;
(
  input  logic clk,
  input  logic rst,
  mdu_if.slave s
);

  state_e      state_q, state_d;
  alu2op_e     op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        accept;
  logic        is_div_in;
  logic        div_last;
  logic [31:0] div_quo, div_rem;
  logic        mul_sgn, div_sgn;
  logic [63:0] mul_a, mul_b, prod;
  logic [31:0] q_fix, r_fix;

  assign is_div_in = s.ALU2Op[1];
  assign mul_sgn   = (op_q == OP_MULT);
  assign div_sgn   = (op_q == OP_DIV);

  // Operands widened to 64 bits so the low 64 product bits are exact for
  // both signed and unsigned multiply.
  assign mul_a = mul_sgn ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
  assign mul_b = mul_sgn ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
  assign prod  = mul_a * mul_b;

  // Sign repair: quotient negative on sign mismatch, remainder follows A.
  assign q_fix = (div_sgn && (a_q[31] ^ b_q[31])) ? (~div_quo + 32'd1) : div_quo;
  assign r_fix = (div_sgn && a_q[31])             ? (~div_rem + 32'd1) : div_rem;

  mdu_div u_div (
    .clk     (clk),
    .rst     (rst),
    .load_i  (accept && is_div_in),
    .step_i  (state_q == S_DIV),
    .clear_i (s.flush),
    .dvd_i   (mag32(s.A, s.ALU2Op == OP_DIV)),
    .dvs_i   (mag32(s.B, s.ALU2Op == OP_DIV)),
    .quo_o   (div_quo),
    .rem_o   (div_rem),
    .last_o  (div_last)
  );

  // Controller next-state, operand latch and HI/LO write selection.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!s.flush) begin
          if (s.start) begin
            accept  = 1'b1;
            op_d    = alu2op_e'(s.ALU2Op);
            a_d     = s.A;
            b_d     = s.B;
            state_d = is_div_in ? S_DIV : S_MUL;
          end
          if (s.RHLWr && s.RHLSel_Wr == WR_LO) lo_d = s.A;
          if (s.RHLWr && s.RHLSel_Wr == WR_HI) hi_d = s.A;
        end
      end
      S_MUL: begin
        state_d = S_IDLE;
        if (!s.flush) begin
          hi_d = prod[63:32];
          lo_d = prod[31:0];
        end
      end
      S_DIV: begin
        if (div_last) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_IDLE;
        // Divide by zero runs to completion but leaves HI/LO untouched.
        if (!s.flush && b_q != 32'd0) begin
          hi_d = r_fix;
          lo_d = q_fix;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (s.flush) state_d = S_IDLE;
  end

  // State, operand and HI/LO registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      op_q    <= OP_MULTU;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign s.busy  = (state_q != S_IDLE);
  assign s.rdata = s.RHLSel_Rd ? hi_q : lo_q;

endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: stimulus pushes expected HI/LO and busy length,
// a monitor checks them whenever busy falls or an idle probe is requested.
module tb_mdu;
  import mdu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic probe_r = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  mdu_if bus();

  mdu dut (
    .clk (clk),
    .rst (rst),
    .s   (bus.slave)
  );

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int          bc;
  } exp_t;

  exp_t sb[$];

  task automatic push(input string n, input logic [31:0] h, input logic [31:0] l, input int c);
    exp_t e;
    e.name = n; e.hi = h; e.lo = l; e.bc = c;
    sb.push_back(e);
  endtask

  task automatic wait_idle(input string n);
    for (int i = 0; i < 100 && bus.busy; i++) begin
      @(posedge clk); #1;
    end
    if (bus.busy) begin
      tests++; fails++;
      $display("FAIL %s timeout: busy still high", n);
    end
  endtask

  task automatic run_op(input string n, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] h, input logic [31:0] l,
                        input int c);
    push(n, h, l, c);
    bus.ALU2Op = op; bus.A = a; bus.B = b; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_idle(n);
  endtask

  task automatic probe(input string n, input logic [31:0] h, input logic [31:0] l);
    push(n, h, l, 0);
    probe_r = 1'b1;
    @(posedge clk); #1;
    probe_r = 1'b0;
  endtask

  task automatic mt(input logic [1:0] sel, input logic [31:0] a);
    bus.RHLWr = 1'b1; bus.RHLSel_Wr = sel; bus.A = a;
    @(posedge clk); #1;
    bus.RHLWr = 1'b0;
  endtask

  // Monitor: reads LO then HI through rdata and compares with the scoreboard.
  initial begin
    logic        busy_prev;
    int          bc;
    logic [31:0] got_hi, got_lo;
    exp_t        e;
    busy_prev     = 1'b0;
    bc            = 0;
    bus.RHLSel_Rd = 1'b0;
    forever begin
      @(negedge clk);
      if ((busy_prev === 1'b1 && bus.busy === 1'b0) || probe_r) begin
        bus.RHLSel_Rd = 1'b0; #1 got_lo = bus.rdata;
        bus.RHLSel_Rd = 1'b1; #1 got_hi = bus.rdata;
        bus.RHLSel_Rd = 1'b0;
        if (sb.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_event: hi=%h lo=%h busy_cycles=%0d, no expectation queued",
                   got_hi, got_lo, bc);
        end else begin
          e = sb.pop_front();
          tests++;
          if (got_hi !== e.hi) begin
            fails++;
            $display("FAIL %s HI: got %h expected %h", e.name, got_hi, e.hi);
          end
          tests++;
          if (got_lo !== e.lo) begin
            fails++;
            $display("FAIL %s LO: got %h expected %h", e.name, got_lo, e.lo);
          end
          tests++;
          if (bc != e.bc) begin
            fails++;
            $display("FAIL %s busy_cycles: got %0d expected %0d", e.name, bc, e.bc);
          end
        end
        bc = 0;
      end
      if (bus.busy === 1'b1) bc++;
      busy_prev = bus.busy;
    end
  end

  // Directed stimulus.
  initial begin
    bus.start = 1'b0; bus.ALU2Op = 2'b00; bus.A = '0; bus.B = '0;
    bus.RHLWr = 1'b0; bus.RHLSel_Wr = 2'b00; bus.flush = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    probe("reset", 32'h0, 32'h0);

    run_op("mult_neg",  OP_MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 1);
    run_op("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1);
    run_op("div_m7_2",  OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33);
    run_op("div_ovf",   OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 33);
    run_op("divu_z",    OP_DIVU,  32'd100,      32'd0,        32'h0,        32'h80000000, 33);

    // Flush during the tenth busy cycle.
    push("flush10", 32'h0, 32'h80000000, 10);
    bus.ALU2Op = OP_DIVU; bus.A = 32'd100; bus.B = 32'd7; bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    bus.flush = 1'b1;
    @(posedge clk); #1 bus.flush = 1'b0;
    wait_idle("flush10");

    // Divide with an MTHI and a start attempted mid-operation.
    push("divu_100_7", 32'd2, 32'd14, 33);
    bus.ALU2Op = OP_DIVU; bus.A = 32'd100; bus.B = 32'd7; bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    bus.RHLWr = 1'b1; bus.RHLSel_Wr = WR_HI; bus.A = 32'h12345678;
    bus.start = 1'b1; bus.ALU2Op = OP_MULTU; bus.B = 32'd2;
    @(posedge clk); #1 bus.RHLWr = 1'b0; bus.start = 1'b0;
    wait_idle("divu_100_7");

    mt(WR_HI, 32'h12345678);
    probe("mthi_idle", 32'h12345678, 32'd14);
    mt(WR_LO, 32'hCAFEF00D);
    probe("mtlo_idle", 32'h12345678, 32'hCAFEF00D);
    mt(WR_RES, 32'hDEADBEEF);
    mt(WR_RSV, 32'hDEADBEEF);
    probe("wsel_res_rsv", 32'h12345678, 32'hCAFEF00D);

    // Start and MTLO presented together with flush are both dropped.
    bus.start = 1'b1; bus.ALU2Op = OP_MULTU; bus.A = 32'd5; bus.B = 32'd5;
    bus.RHLWr = 1'b1; bus.RHLSel_Wr = WR_LO; bus.flush = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0; bus.RHLWr = 1'b0; bus.flush = 1'b0;
    probe("flush_start", 32'h12345678, 32'hCAFEF00D);

    run_op("multu_small", OP_MULTU, 32'd7, 32'd6,        32'h0, 32'd42,       1);
    run_op("div_7_m2",    OP_DIV,   32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 33);

    // Reset during the fifth busy cycle of a divide.
    push("rst_mid", 32'h0, 32'h0, 5);
    bus.ALU2Op = OP_DIVU; bus.A = 32'd1000; bus.B = 32'd3; bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    wait_idle("rst_mid");

    run_op("multu_after_rst", OP_MULTU, 32'h00010000, 32'h00010000, 32'h1, 32'h0, 1);

    for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      tests++; fails++;
      $display("FAIL drain: %0d expectations never checked, expected 0", sb.size());
    end
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
